// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK counter sequencer: command encodings and FSM states.
package jk_ctrl_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_UP   = 2'b10;
   localparam logic [1:0] OP_DOWN = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command handshake and status bundle between datapath logic and the JK sequencer.
interface jk_counter_ctrl_if #(parameter int WIDTH = 4);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             abort;
   logic [WIDTH-1:0] Q;
   logic             busy;
   logic             done;
   logic             wrap;

   modport master (
      output cmd_valid, cmd_op, cmd_data, abort,
      input  cmd_ready, Q, busy, done, wrap
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, abort,
      output cmd_ready, Q, busy, done, wrap
   );

endinterface

// File: rtl/jk_counter_ctrl_bit.sv
// Single JK storage stage: hold, reset, set or toggle on each rising clock edge.
module jk_bit (
   input  logic clk,
   input  logic rstn,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer that drives a bank of JK stages to hold, load, or count up/down
// for a programmed number of steps, with abort and sticky wrap reporting.
module jk_counter_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rstn,
   jk_counter_ctrl_if.slave   bus
);

   state_t           state;
   state_t           state_next;
   logic [1:0]       op_lat;
   logic [WIDTH-1:0] data_lat;
   logic [WIDTH-1:0] step_cnt;
   logic             wrap;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] tog;
   logic             accept;
   logic             do_step;
   logic             wrap_hit;
   logic             is_count_op;

   assign accept      = bus.cmd_valid && (state == ST_IDLE);
   assign do_step     = (state == ST_RUN) && !bus.abort;
   assign is_count_op = (bus.cmd_op == OP_UP) || (bus.cmd_op == OP_DOWN);
   assign wrap_hit    = do_step && ((op_lat == OP_UP) ? (&q) : (~|q));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (bus.cmd_op)
                  OP_NOP:  state_next = ST_DONE;
                  OP_LOAD: state_next = ST_LOAD;
                  default: state_next = (bus.cmd_data != '0) ? ST_RUN : ST_DONE;
               endcase
            end
         end
         ST_LOAD: state_next = ST_DONE;
         ST_RUN: begin
            if (bus.abort || (step_cnt == WIDTH'(1))) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // A stage toggles when every lower stage is at the carry (up) or borrow (down) value.
   always_comb begin
      logic chain;
      j     = '0;
      k     = '0;
      tog   = '0;
      chain = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i] = chain;
         chain  = chain & ((op_lat == OP_UP) ? q[i] : ~q[i]);
      end
      if (state == ST_LOAD) begin
         j = data_lat;
         k = ~data_lat;
      end else if (do_step) begin
         j = tog;
         k = tog;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_lat   <= OP_NOP;
         data_lat <= '0;
         step_cnt <= '0;
         wrap     <= 1'b0;
      end else if (accept) begin
         op_lat   <= bus.cmd_op;
         data_lat <= bus.cmd_data;
         step_cnt <= is_count_op ? bus.cmd_data : '0;
         wrap     <= 1'b0;
      end else if (state == ST_RUN) begin
         step_cnt <= bus.abort ? '0 : (step_cnt - WIDTH'(1));
         if (wrap_hit) begin
            wrap <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      jk_bit u_bit (
         .clk  (clk),
         .rstn (rstn),
         .j    (j[i]),
         .k    (k[i]),
         .q    (q[i])
      );
   end

   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = (state == ST_DONE);
   assign bus.wrap      = wrap;
   assign bus.Q         = q;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl: directed scenarios plus randomized commands
// compared against a modulo-arithmetic reference of the counter value and wrap flag.
module tb_jk_counter_ctrl;
   import jk_ctrl_pkg::*;

   localparam int W = 4;
   localparam logic [W-1:0] ALL1 = '1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   passes = 0;

   logic [W-1:0] m_q;
   logic         m_wrap;

   jk_counter_ctrl_if #(.WIDTH(W)) bus ();

   jk_counter_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [W-1:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_data  = W'($urandom);
      m_wrap        = 1'b0;
   endtask

   task automatic model_step(input bit up);
      if (up) begin
         if (m_q == ALL1) m_wrap = 1'b1;
         m_q = W'(m_q + 1);
      end else begin
         if (m_q == '0) m_wrap = 1'b1;
         m_q = W'(m_q - 1);
      end
   endtask

   task automatic test_reset();
      logic seen_done;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;
      bus.abort     = 1'b0;
      rstn          = 1'b0;
      repeat (3) tick();
      checks++; if (bus.Q !== 4'h0) $display("[TB] FAIL reset_q: got %h expected %h", bus.Q, 4'h0); else passes++;
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.cmd_ready); else passes++;
      checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
      checks++; if (bus.wrap !== 1'b0) $display("[TB] FAIL reset_wrap: got %b expected 0", bus.wrap); else passes++;
      rstn = 1'b1;
      tick();
      m_q = '0;
      m_wrap = 1'b0;
      send(OP_UP, 4'd10);
      repeat (3) tick();
      checks++; if (bus.Q !== 4'h3) $display("[TB] FAIL midrun_q: got %h expected %h", bus.Q, 4'h3); else passes++;
      #1 rstn = 1'b0;
      #1;
      checks++; if (bus.Q !== 4'h0) $display("[TB] FAIL midrun_reset_q: got %h expected 0", bus.Q); else passes++;
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL midrun_reset_ready: got %b expected 1", bus.cmd_ready); else passes++;
      checks++; if (bus.wrap !== 1'b0) $display("[TB] FAIL midrun_reset_wrap: got %b expected 0", bus.wrap); else passes++;
      #2 rstn = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen_done = seen_done | bus.done;
      end
      checks++; if (seen_done !== 1'b0) $display("[TB] FAIL midrun_no_done: got %b expected 0", seen_done); else passes++;
      checks++; if (bus.Q !== 4'h0) $display("[TB] FAIL midrun_after_q: got %h expected 0", bus.Q); else passes++;
      m_q = '0;
   endtask

   task automatic test_load();
      send(OP_LOAD, 4'hA);
      checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL load_busy: got %b expected 1", bus.busy); else passes++;
      checks++; if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL load_ready_low: got %b expected 0", bus.cmd_ready); else passes++;
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL load_done_early: got %b expected 0", bus.done); else passes++;
      tick();
      checks++; if (bus.Q !== 4'hA) $display("[TB] FAIL load_q: got %h expected %h", bus.Q, 4'hA); else passes++;
      checks++; if (bus.done !== 1'b1) $display("[TB] FAIL load_done: got %b expected 1", bus.done); else passes++;
      tick();
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL load_done_pulse: got %b expected 0", bus.done); else passes++;
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL load_ready_back: got %b expected 1", bus.cmd_ready); else passes++;
      m_q = 4'hA;
   endtask

   task automatic test_up_wrap();
      send(OP_LOAD, 4'hE);
      tick();
      tick();
      m_q = 4'hE;
      checks++; if (bus.Q !== 4'hE) $display("[TB] FAIL upwrap_start: got %h expected %h", bus.Q, 4'hE); else passes++;
      send(OP_UP, 4'd3);
      for (int s = 1; s <= 3; s++) begin
         tick();
         model_step(1'b1);
         checks++; if (bus.Q !== m_q) $display("[TB] FAIL upwrap_q%0d: got %h expected %h", s, bus.Q, m_q); else passes++;
         checks++; if (bus.wrap !== m_wrap) $display("[TB] FAIL upwrap_wrap%0d: got %b expected %b", s, bus.wrap, m_wrap); else passes++;
         checks++; if (bus.done !== (s == 3)) $display("[TB] FAIL upwrap_done%0d: got %b expected %b", s, bus.done, (s == 3)); else passes++;
      end
      tick();
      checks++; if (bus.wrap !== 1'b1) $display("[TB] FAIL upwrap_sticky: got %b expected 1", bus.wrap); else passes++;
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL upwrap_ready: got %b expected 1", bus.cmd_ready); else passes++;
   endtask

   task automatic test_down_and_zero();
      send(OP_LOAD, 4'h1);
      checks++; if (bus.wrap !== 1'b0) $display("[TB] FAIL accept_clears_wrap: got %b expected 0", bus.wrap); else passes++;
      tick();
      tick();
      m_q = 4'h1;
      send(OP_DOWN, 4'd2);
      for (int s = 1; s <= 2; s++) begin
         tick();
         model_step(1'b0);
         checks++; if (bus.Q !== m_q) $display("[TB] FAIL down_q%0d: got %h expected %h", s, bus.Q, m_q); else passes++;
      end
      checks++; if (bus.wrap !== 1'b1) $display("[TB] FAIL down_wrap: got %b expected 1", bus.wrap); else passes++;
      tick();
      send(OP_UP, 4'd0);
      checks++; if (bus.done !== 1'b1) $display("[TB] FAIL zero_done: got %b expected 1", bus.done); else passes++;
      checks++; if (bus.Q !== 4'hF) $display("[TB] FAIL zero_q: got %h expected %h", bus.Q, 4'hF); else passes++;
      checks++; if (bus.wrap !== 1'b0) $display("[TB] FAIL zero_wrap: got %b expected 0", bus.wrap); else passes++;
      tick();
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL zero_ready: got %b expected 1", bus.cmd_ready); else passes++;
   endtask

   task automatic test_abort();
      send(OP_LOAD, 4'h0);
      tick();
      tick();
      m_q = 4'h0;
      send(OP_UP, 4'd8);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 4'h5;
      for (int s = 1; s <= 4; s++) begin
         if (s == 4) bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         if (s < 4) begin
            model_step(1'b1);
            checks++; if (bus.Q !== m_q) $display("[TB] FAIL abort_q%0d: got %h expected %h", s, bus.Q, m_q); else passes++;
            checks++; if (bus.cmd_ready !== 1'b0) $display("[TB] FAIL abort_ready%0d: got %b expected 0", s, bus.cmd_ready); else passes++;
         end else begin
            checks++; if (bus.Q !== 4'h3) $display("[TB] FAIL abort_final_q: got %h expected %h", bus.Q, 4'h3); else passes++;
            checks++; if (bus.done !== 1'b1) $display("[TB] FAIL abort_done: got %b expected 1", bus.done); else passes++;
         end
      end
      bus.cmd_valid = 1'b0;
      tick();
      checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL abort_ready_back: got %b expected 1", bus.cmd_ready); else passes++;
      checks++; if (bus.Q !== 4'h3) $display("[TB] FAIL abort_no_load: got %h expected %h", bus.Q, 4'h3); else passes++;
      checks++; if (bus.done !== 1'b0) $display("[TB] FAIL abort_done_pulse: got %b expected 0", bus.done); else passes++;
      m_q = 4'h3;
   endtask

   task automatic test_back_to_back();
      int accepts;
      int dones;
      accepts = 0;
      dones   = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_NOP;
      for (int i = 0; i < 10; i++) begin
         if (bus.cmd_ready) accepts++;
         tick();
         if (bus.done) dones++;
         checks++; if (bus.Q !== m_q) $display("[TB] FAIL b2b_q%0d: got %h expected %h", i, bus.Q, m_q); else passes++;
      end
      bus.cmd_valid = 1'b0;
      checks++; if (accepts !== 5) $display("[TB] FAIL b2b_accepts: got %0d expected 5", accepts); else passes++;
      checks++; if (dones !== 5) $display("[TB] FAIL b2b_dones: got %0d expected 5", dones); else passes++;
      m_wrap = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [W-1:0] data;
      int           ab;
      for (int n = 0; n < 40; n++) begin
         op   = 2'($urandom_range(0, 3));
         data = W'($urandom);
         send(op, data);
         if (op == OP_NOP || ((op == OP_UP || op == OP_DOWN) && data == '0)) begin
            checks++; if (bus.done !== 1'b1) $display("[TB] FAIL rnd%0d_imm_done: got %b expected 1", n, bus.done); else passes++;
            checks++; if (bus.Q !== m_q) $display("[TB] FAIL rnd%0d_imm_q: got %h expected %h", n, bus.Q, m_q); else passes++;
            checks++; if (bus.wrap !== 1'b0) $display("[TB] FAIL rnd%0d_imm_wrap: got %b expected 0", n, bus.wrap); else passes++;
         end else if (op == OP_LOAD) begin
            bus.cmd_valid = 1'($urandom);
            tick();
            m_q = data;
            checks++; if (bus.Q !== m_q) $display("[TB] FAIL rnd%0d_load_q: got %h expected %h", n, bus.Q, m_q); else passes++;
            checks++; if (bus.done !== 1'b1) $display("[TB] FAIL rnd%0d_load_done: got %b expected 1", n, bus.done); else passes++;
         end else begin
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(data))) : 0;
            for (int s = 1; s <= int'(data); s++) begin
               bus.cmd_valid = 1'($urandom);
               bus.cmd_op    = 2'($urandom);
               if (s == ab) bus.abort = 1'b1;
               tick();
               bus.abort = 1'b0;
               if (s == ab) begin
                  checks++; if (bus.Q !== m_q) $display("[TB] FAIL rnd%0d_abort_q: got %h expected %h", n, bus.Q, m_q); else passes++;
                  checks++; if (bus.done !== 1'b1) $display("[TB] FAIL rnd%0d_abort_done: got %b expected 1", n, bus.done); else passes++;
                  break;
               end
               model_step(op == OP_UP);
               checks++; if (bus.Q !== m_q) $display("[TB] FAIL rnd%0d_q%0d: got %h expected %h", n, s, bus.Q, m_q); else passes++;
               checks++; if (bus.wrap !== m_wrap) $display("[TB] FAIL rnd%0d_wrap%0d: got %b expected %b", n, s, bus.wrap, m_wrap); else passes++;
               checks++; if (bus.done !== (s == int'(data))) $display("[TB] FAIL rnd%0d_done%0d: got %b expected %b", n, s, bus.done, (s == int'(data))); else passes++;
            end
         end
         bus.cmd_valid = 1'b0;
         tick();
         checks++; if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL rnd%0d_ready: got %b expected 1", n, bus.cmd_ready); else passes++;
         checks++; if (bus.done !== 1'b0) $display("[TB] FAIL rnd%0d_done_end: got %b expected 0", n, bus.done); else passes++;
         checks++; if (bus.Q !== m_q) $display("[TB] FAIL rnd%0d_q_end: got %h expected %h", n, bus.Q, m_q); else passes++;
         checks++; if (bus.wrap !== m_wrap) $display("[TB] FAIL rnd%0d_wrap_end: got %b expected %b", n, bus.wrap, m_wrap); else passes++;
      end
   endtask

   initial begin
      $display("[TB] starting jk_counter_ctrl bench");
      test_reset();
      test_load();
      test_up_wrap();
      test_down_and_zero();
      test_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
